// File: rtl/coeff_pingpong_buffer.sv
// Multi-bank coefficient buffer: a producer fills banks in rotation while a
// consumer drains completed banks, with occupancy tracking and a sticky misuse flag.
module coeff_pingpong_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_DEPTH = 1024,
  parameter int NUM_BANKS   = 2,
  localparam int AW = $clog2(BLOCK_DEPTH),
  localparam int BW = $clog2(NUM_BANKS + 1)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  Write_Enable_I,
  input  logic [AW-1:0]         Write_Address_I,
  input  logic [DATA_WIDTH-1:0] Write_Data_I,
  input  logic                  Write_Done_I,
  output logic                  Write_Ready_O,
  input  logic                  Read_Enable_I,
  input  logic [AW-1:0]         Read_Address_I,
  output logic [DATA_WIDTH-1:0] Read_Data_O,
  output logic                  Read_Valid_O,
  input  logic                  Read_Done_I,
  output logic                  Read_Ready_O,
  output logic [BW-1:0]         Full_Count_O,
  output logic                  Error_O
);

  localparam int              PW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [PW-1:0]   LAST_BANK  = PW'(NUM_BANKS - 1);
  localparam logic [BW-1:0]   FULL_COUNT = BW'(NUM_BANKS);

  logic [PW-1:0] wr_bank_q, wr_bank_d;
  logic [PW-1:0] rd_bank_q, rd_bank_d;
  logic [PW-1:0] rd_sel_q, rd_sel_d;
  logic [BW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          clear_q, clear_d;
  logic          error_q, error_d;

  logic wr_ready, rd_ready;
  logic wr_accept, wr_done_accept;
  logic rd_accept, rd_done_accept;

  logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];

  assign wr_ready = (count_q < FULL_COUNT);
  assign rd_ready = (count_q != '0);

  // Accepts are masked by reset so nothing touches the memories in a reset cycle.
  assign wr_accept      = resetn & Write_Enable_I & wr_ready;
  assign wr_done_accept = resetn & Write_Done_I   & wr_ready;
  assign rd_accept      = resetn & Read_Enable_I  & rd_ready;
  assign rd_done_accept = resetn & Read_Done_I    & rd_ready;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BLOCK_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clock) begin
      if (wr_accept && (wr_bank_q == PW'(gi))) begin
        mem[Write_Address_I] <= Write_Data_I;
      end
    end

    always_ff @(posedge clock) begin
      if (rd_accept && (rd_bank_q == PW'(gi))) begin
        rd_q <= mem[Read_Address_I];
      end
    end

    assign bank_rd[gi] = rd_q;
  end

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_sel_d  = rd_sel_q;
    count_d   = count_q;
    valid_d   = rd_accept;
    clear_d   = clear_q;
    error_d   = error_q;

    if (wr_done_accept) begin
      wr_bank_d = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + PW'(1);
    end
    if (rd_done_accept) begin
      rd_bank_d = (rd_bank_q == LAST_BANK) ? '0 : rd_bank_q + PW'(1);
    end

    // The output mux follows the bank that served the most recent accepted read.
    if (rd_accept) begin
      rd_sel_d = rd_bank_q;
      clear_d  = 1'b0;
    end

    case ({wr_done_accept, rd_done_accept})
      2'b10:   count_d = count_q + BW'(1);
      2'b01:   count_d = count_q - BW'(1);
      default: count_d = count_q;
    endcase

    if (((Write_Enable_I | Write_Done_I) & ~wr_ready) |
        ((Read_Enable_I  | Read_Done_I)  & ~rd_ready)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      rd_sel_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      clear_q   <= 1'b1;
      error_q   <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_sel_q  <= rd_sel_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      clear_q   <= clear_d;
      error_q   <= error_d;
    end
  end

  // clear_q forces zero data after reset until the first accepted read lands.
  assign Read_Data_O   = clear_q ? '0 : bank_rd[rd_sel_q];
  assign Read_Valid_O  = valid_q;
  assign Write_Ready_O = wr_ready;
  assign Read_Ready_O  = rd_ready;
  assign Full_Count_O  = count_q;
  assign Error_O       = error_q;

endmodule

// File: tb/tb_coeff_pingpong_buffer.sv
// Directed bench for coeff_pingpong_buffer: a 2-bank/1024-deep instance and a
// 3-bank/64-deep instance exercised with hand-computed expectations.
module tb_coeff_pingpong_buffer;

  localparam int D0 = 1024;
  localparam int D1 = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Two-bank instance
  logic        resetn = 1'b0;
  logic        we = 1'b0, wdone = 1'b0, re = 1'b0, rdone = 1'b0;
  logic [9:0]  wa = '0, ra = '0;
  logic [31:0] wd = '0;
  logic        wready, rvalid, rready, err;
  logic [31:0] rdata;
  logic [1:0]  fcount;

  // Three-bank instance
  logic        b_resetn = 1'b0;
  logic        b_we = 1'b0, b_wdone = 1'b0, b_re = 1'b0, b_rdone = 1'b0;
  logic [5:0]  b_wa = '0, b_ra = '0;
  logic [31:0] b_wd = '0;
  logic        b_wready, b_rvalid, b_rready, b_err;
  logic [31:0] b_rdata;
  logic [1:0]  b_fcount;

  int checks = 0;
  int errors = 0;

  coeff_pingpong_buffer #(.DATA_WIDTH(32), .BLOCK_DEPTH(D0), .NUM_BANKS(2)) dut0 (
    .clock(clock), .resetn(resetn),
    .Write_Enable_I(we), .Write_Address_I(wa), .Write_Data_I(wd), .Write_Done_I(wdone),
    .Write_Ready_O(wready),
    .Read_Enable_I(re), .Read_Address_I(ra), .Read_Data_O(rdata), .Read_Valid_O(rvalid),
    .Read_Done_I(rdone), .Read_Ready_O(rready),
    .Full_Count_O(fcount), .Error_O(err)
  );

  coeff_pingpong_buffer #(.DATA_WIDTH(32), .BLOCK_DEPTH(D1), .NUM_BANKS(3)) dut1 (
    .clock(clock), .resetn(b_resetn),
    .Write_Enable_I(b_we), .Write_Address_I(b_wa), .Write_Data_I(b_wd), .Write_Done_I(b_wdone),
    .Write_Ready_O(b_wready),
    .Read_Enable_I(b_re), .Read_Address_I(b_ra), .Read_Data_O(b_rdata), .Read_Valid_O(b_rvalid),
    .Read_Done_I(b_rdone), .Read_Ready_O(b_rready),
    .Full_Count_O(b_fcount), .Error_O(b_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill0(input logic [31:0] base);
    for (int a = 0; a < D0; a++) begin
      we = 1'b1; wa = 10'(a); wd = base + 32'(a); wdone = (a == D0 - 1);
      tick();
    end
    we = 1'b0; wdone = 1'b0;
  endtask

  task automatic read0(input logic [9:0] addr, input logic done);
    re = 1'b1; ra = addr; rdone = done;
    tick();
    re = 1'b0; rdone = 1'b0;
  endtask

  task automatic fill1(input logic [31:0] base);
    for (int a = 0; a < D1; a++) begin
      b_we = 1'b1; b_wa = 6'(a); b_wd = base + 32'(a); b_wdone = (a == D1 - 1);
      tick();
    end
    b_we = 1'b0; b_wdone = 1'b0;
  endtask

  task automatic read1(input logic [5:0] addr, input logic done);
    b_re = 1'b1; b_ra = addr; b_rdone = done;
    tick();
    b_re = 1'b0; b_rdone = 1'b0;
  endtask

  initial begin
    // Reset with every strobe asserted: none of them may take effect.
    we = 1'b1; wdone = 1'b1; re = 1'b1; rdone = 1'b1; wd = 32'h5555;
    tick(); tick();
    resetn = 1'b1; we = 1'b0; wdone = 1'b0; re = 1'b0; rdone = 1'b0;
    check("rst_count", 64'(fcount), 64'd0);
    check("rst_wready", 64'(wready), 64'd1);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_valid", 64'(rvalid), 64'd0);
    check("rst_data", 64'(rdata), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // Read from an empty buffer is rejected and flagged.
    read0(10'd3, 1'b0);
    check("empty_rd_valid", 64'(rvalid), 64'd0);
    check("empty_rd_err", 64'(err), 64'd1);
    read0(10'd3, 1'b1);
    check("empty_done_count", 64'(fcount), 64'd0);

    resetn = 1'b0; tick(); resetn = 1'b1;
    check("rst2_err", 64'(err), 64'd0);

    // First bank: last write shares its cycle with Write_Done.
    fill0(32'h1000);
    check("fill0_count", 64'(fcount), 64'd1);
    check("fill0_rready", 64'(rready), 64'd1);
    check("fill0_wready", 64'(wready), 64'd1);
    read0(10'd5, 1'b0);
    check("rd5_data", 64'(rdata), 64'h1005);
    check("rd5_valid", 64'(rvalid), 64'd1);
    tick();
    check("idle_valid", 64'(rvalid), 64'd0);
    check("idle_hold", 64'(rdata), 64'h1005);
    read0(10'd1023, 1'b0);
    check("rd1023_data", 64'(rdata), 64'h13FF);

    // Second bank; its final cycle also reads addr 7 and releases bank 0.
    for (int a = 0; a < D0 - 1; a++) begin
      we = 1'b1; wa = 10'(a); wd = 32'h2000 + 32'(a);
      tick();
    end
    we = 1'b1; wa = 10'd1023; wd = 32'h23FF; wdone = 1'b1;
    re = 1'b1; ra = 10'd7; rdone = 1'b1;
    tick();
    we = 1'b0; wdone = 1'b0; re = 1'b0; rdone = 1'b0;
    check("both_done_count", 64'(fcount), 64'd1);
    check("done_rd_old_bank", 64'(rdata), 64'h1007);
    check("done_rd_valid", 64'(rvalid), 64'd1);
    read0(10'd7, 1'b0);
    check("rd_next_bank", 64'(rdata), 64'h2007);
    read0(10'd1023, 1'b0);
    check("last_wr_old_bank", 64'(rdata), 64'h23FF);

    // Write pointer wrapped to bank 0.
    we = 1'b1; wa = 10'd9; wd = 32'h3009; wdone = 1'b1;
    tick();
    we = 1'b0; wdone = 1'b0;
    check("full_count", 64'(fcount), 64'd2);
    check("full_wready", 64'(wready), 64'd0);
    check("pre_ovf_err", 64'(err), 64'd0);

    // Overflow write and done are both ignored.
    we = 1'b1; wa = 10'd0; wd = 32'h0000DEAD; wdone = 1'b1;
    tick();
    we = 1'b0; wdone = 1'b0;
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_count", 64'(fcount), 64'd2);

    read0(10'd0, 1'b1);
    check("rel_bank1_data", 64'(rdata), 64'h2000);
    check("rel_count", 64'(fcount), 64'd1);
    check("rel_wready", 64'(wready), 64'd1);
    read0(10'd0, 1'b0);
    check("ovf_not_written", 64'(rdata), 64'h1000);
    read0(10'd9, 1'b0);
    check("wrap_bank0_data", 64'(rdata), 64'h3009);
    check("err_sticky", 64'(err), 64'd1);

    // Reset mid-fill with a read outstanding and Done pulses asserted.
    we = 1'b1; wa = 10'd3; wd = 32'h4003;
    tick();
    we = 1'b0;
    read0(10'd9, 1'b0);
    check("pre_rst_valid", 64'(rvalid), 64'd1);
    resetn = 1'b0; wdone = 1'b1; re = 1'b1; rdone = 1'b1;
    tick();
    resetn = 1'b1; wdone = 1'b0; re = 1'b0; rdone = 1'b0;
    check("midrst_count", 64'(fcount), 64'd0);
    check("midrst_wready", 64'(wready), 64'd1);
    check("midrst_rready", 64'(rready), 64'd0);
    check("midrst_valid", 64'(rvalid), 64'd0);
    check("midrst_data", 64'(rdata), 64'd0);
    check("midrst_err", 64'(err), 64'd0);

    // Three-bank instance: fourth fill must land in bank 0.
    tick();
    b_resetn = 1'b1;
    fill1(32'h100);
    fill1(32'h200);
    fill1(32'h300);
    check("b_full_count", 64'(b_fcount), 64'd3);
    check("b_full_wready", 64'(b_wready), 64'd0);
    read1(6'd10, 1'b1);
    check("b_bank0_data", 64'(b_rdata), 64'h10A);
    check("b_drain_count", 64'(b_fcount), 64'd2);
    fill1(32'h400);
    check("b_refill_count", 64'(b_fcount), 64'd3);
    read1(6'd10, 1'b1);
    check("b_bank1_data", 64'(b_rdata), 64'h20A);
    read1(6'd10, 1'b1);
    check("b_bank2_data", 64'(b_rdata), 64'h30A);
    read1(6'd10, 1'b0);
    check("b_wrap_data", 64'(b_rdata), 64'h40A);
    check("b_final_count", 64'(b_fcount), 64'd1);
    check("b_err", 64'(b_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
